// File: rtl/bellek_yanitlayici_if.sv
// Bus bundle between the core and bellek_yanitlayici.
// Signal names keep the responder's point of view (_i = into responder, _o = out of it).
//   l1b_* : instruction fetch port (address in, word and stall out)
//   bib_* : data port (request, address, write data/mask/flag in; read data and stall out)
// Modports: slave = responder side, master = core / testbench side.
interface bellek_yanitlayici_if #(
    parameter int unsigned VERI_GEN  = 32,
    parameter int unsigned ADRES_GEN = 32
);
    logic [ADRES_GEN-1:0]  l1b_adres_i;
    logic [VERI_GEN-1:0]   l1b_deger_o;
    logic                  l1b_bekle_o;
    logic                  bib_sec_i;
    logic [ADRES_GEN-1:0]  bib_adr_i;
    logic [VERI_GEN-1:0]   bib_veri_i;
    logic [VERI_GEN/8-1:0] bib_veri_maske_i;
    logic                  bib_yaz_gecerli_i;
    logic [VERI_GEN-1:0]   bib_veri_o;
    logic                  bib_durdur_o;

    modport slave (
        input  l1b_adres_i,
        output l1b_deger_o,
        output l1b_bekle_o,
        input  bib_sec_i,
        input  bib_adr_i,
        input  bib_veri_i,
        input  bib_veri_maske_i,
        input  bib_yaz_gecerli_i,
        output bib_veri_o,
        output bib_durdur_o
    );

    modport master (
        output l1b_adres_i,
        input  l1b_deger_o,
        input  l1b_bekle_o,
        output bib_sec_i,
        output bib_adr_i,
        output bib_veri_i,
        output bib_veri_maske_i,
        output bib_yaz_gecerli_i,
        input  bib_veri_o,
        input  bib_durdur_o
    );
endinterface

// File: rtl/bellek_yanitlayici.sv
// Memory responder with configurable wait states for the core's instruction (l1b) and data
// (bib) ports. Data writes are byte-masked; out-of-range accesses set a sticky error flag.
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   bus                : bellek_yanitlayici_if.slave (instruction and data port signals)
//   hata_o             : sticky out-of-range flag
//   b_istek_sayisi_o   : completed instruction fetches
//   v_istek_sayisi_o   : completed data transactions
module bellek_yanitlayici #(
    parameter int unsigned          VERI_GEN    = 32,
    parameter int unsigned          ADRES_GEN   = 32,
    parameter int unsigned          DERINLIK    = 4096,
    parameter logic [ADRES_GEN-1:0] ADRES_TABAN = ADRES_GEN'(32'h4000_0000),
    parameter int unsigned          B_GECIKME   = 1,
    parameter int unsigned          V_GECIKME   = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    bellek_yanitlayici_if.slave        bus,
    output logic                       hata_o,
    output logic [31:0]                b_istek_sayisi_o,
    output logic [31:0]                v_istek_sayisi_o
);
    localparam int unsigned          IdxW  = $clog2(DERINLIK);
    localparam int                   Bayt  = VERI_GEN / 8;
    localparam logic [ADRES_GEN-1:0] Boyut = ADRES_GEN'(4 * DERINLIK);

    typedef enum logic [1:0] {BBosta, BSay, BHazir} b_durum_e;
    typedef enum logic [1:0] {VBosta, VSay, VTamam} v_durum_e;

    logic [VERI_GEN-1:0] mem_q [DERINLIK];

    b_durum_e            b_durum_q, b_durum_d;
    logic [3:0]          b_sayac_q, b_sayac_d;
    logic [ADRES_GEN-1:0] b_adres_q, b_adres_d;
    logic [VERI_GEN-1:0] l1b_deger_q, l1b_deger_d;
    logic [31:0]         b_sayi_q, b_sayi_d;
    logic                b_bitti;

    v_durum_e            v_durum_q, v_durum_d;
    logic [3:0]          v_sayac_q, v_sayac_d;
    logic [ADRES_GEN-1:0] v_adres_q, v_adres_d;
    logic [VERI_GEN-1:0] v_veri_q, v_veri_d;
    logic [Bayt-1:0]     v_maske_q, v_maske_d;
    logic                v_yaz_q, v_yaz_d;
    logic [VERI_GEN-1:0] bib_veri_q, bib_veri_d;
    logic [31:0]         v_sayi_q, v_sayi_d;
    logic                hata_q, hata_d;

    // Address decode. The data side decodes the live bus address while idle so that a
    // single-wait read can load its result on the request edge.
    logic [ADRES_GEN-1:0] b_ofs, v_kaynak, v_ofs;
    logic                 b_aralik, v_aralik;
    logic [IdxW-1:0]      b_idx, v_idx;
    logic [VERI_GEN-1:0]  v_okuma;
    logic                 mem_yaz;
    logic                 unused_ofs;

    assign b_ofs    = b_adres_q - ADRES_TABAN;
    assign b_aralik = (b_adres_q >= ADRES_TABAN) && (b_ofs < Boyut);
    assign b_idx    = b_ofs[IdxW+1:2];

    assign v_kaynak = (v_durum_q == VBosta) ? bus.bib_adr_i : v_adres_q;
    assign v_ofs    = v_kaynak - ADRES_TABAN;
    assign v_aralik = (v_kaynak >= ADRES_TABAN) && (v_ofs < Boyut);
    assign v_idx    = v_ofs[IdxW+1:2];
    assign v_okuma  = v_aralik ? mem_q[v_idx] : '0;

    assign unused_ofs = ^{b_ofs[ADRES_GEN-1:IdxW+2], b_ofs[1:0],
                          v_ofs[ADRES_GEN-1:IdxW+2], v_ofs[1:0]};

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_durum_q   <= BBosta;
            b_sayac_q   <= '0;
            b_adres_q   <= '0;
            l1b_deger_q <= '0;
            b_sayi_q    <= '0;
            v_durum_q   <= VBosta;
            v_sayac_q   <= '0;
            v_adres_q   <= '0;
            v_veri_q    <= '0;
            v_maske_q   <= '0;
            v_yaz_q     <= 1'b0;
            bib_veri_q  <= '0;
            v_sayi_q    <= '0;
            hata_q      <= 1'b0;
        end else begin
            b_durum_q   <= b_durum_d;
            b_sayac_q   <= b_sayac_d;
            b_adres_q   <= b_adres_d;
            l1b_deger_q <= l1b_deger_d;
            b_sayi_q    <= b_sayi_d;
            v_durum_q   <= v_durum_d;
            v_sayac_q   <= v_sayac_d;
            v_adres_q   <= v_adres_d;
            v_veri_q    <= v_veri_d;
            v_maske_q   <= v_maske_d;
            v_yaz_q     <= v_yaz_d;
            bib_veri_q  <= bib_veri_d;
            v_sayi_q    <= v_sayi_d;
            hata_q      <= hata_d;
        end
    end

    // Memory has no reset; the write lands at the closing edge of the completion cycle, so a
    // fetch finishing on the same edge still sees the old word.
    assign mem_yaz = (v_durum_q == VTamam) && v_yaz_q && v_aralik;

    always_ff @(posedge clk_i) begin
        if (mem_yaz) begin
            for (int i = 0; i < Bayt; i++) begin
                if (v_maske_q[i]) mem_q[v_idx][8*i +: 8] <= v_veri_q[8*i +: 8];
            end
        end
    end

    // Instruction FSM next state. Idle is only reachable through reset, so it always
    // starts a fetch of the current address.
    always_comb begin
        b_durum_d   = b_durum_q;
        b_sayac_d   = b_sayac_q;
        b_adres_d   = b_adres_q;
        l1b_deger_d = l1b_deger_q;
        b_sayi_d    = b_sayi_q;
        b_bitti     = 1'b0;
        unique case (b_durum_q)
            BBosta: begin
                b_durum_d = BSay;
                b_sayac_d = '0;
                b_adres_d = bus.l1b_adres_i;
            end
            BSay: begin
                if (b_sayac_q == 4'(B_GECIKME - 1)) begin
                    b_durum_d   = BHazir;
                    l1b_deger_d = b_aralik ? mem_q[b_idx] : '0;
                    b_sayi_d    = b_sayi_q + 32'd1;
                    b_bitti     = 1'b1;
                end else begin
                    b_sayac_d = b_sayac_q + 4'd1;
                end
            end
            BHazir: begin
                if (bus.l1b_adres_i != b_adres_q) begin
                    b_durum_d = BSay;
                    b_sayac_d = '0;
                    b_adres_d = bus.l1b_adres_i;
                end
            end
            default: b_durum_d = BBosta;
        endcase
    end

    // Data FSM next state. The request cycle itself counts as the first wait cycle, so a
    // transaction takes V_GECIKME stall cycles plus one completion cycle.
    always_comb begin
        v_durum_d  = v_durum_q;
        v_sayac_d  = v_sayac_q;
        v_adres_d  = v_adres_q;
        v_veri_d   = v_veri_q;
        v_maske_d  = v_maske_q;
        v_yaz_d    = v_yaz_q;
        bib_veri_d = bib_veri_q;
        v_sayi_d   = v_sayi_q;
        unique case (v_durum_q)
            VBosta: begin
                if (bus.bib_sec_i) begin
                    v_adres_d = bus.bib_adr_i;
                    v_veri_d  = bus.bib_veri_i;
                    v_maske_d = bus.bib_veri_maske_i;
                    v_yaz_d   = bus.bib_yaz_gecerli_i;
                    v_sayac_d = 4'd1;
                    if (V_GECIKME == 1) begin
                        v_durum_d = VTamam;
                        if (!bus.bib_yaz_gecerli_i) bib_veri_d = v_okuma;
                    end else begin
                        v_durum_d = VSay;
                    end
                end
            end
            VSay: begin
                if (!bus.bib_sec_i) begin
                    v_durum_d = VBosta;
                end else if (v_sayac_q == 4'(V_GECIKME - 1)) begin
                    v_durum_d = VTamam;
                    if (!v_yaz_q) bib_veri_d = v_okuma;
                end else begin
                    v_sayac_d = v_sayac_q + 4'd1;
                end
            end
            VTamam: begin
                v_durum_d = VBosta;
                v_sayi_d  = v_sayi_q + 32'd1;
            end
            default: v_durum_d = VBosta;
        endcase
    end

    assign hata_d = hata_q | (b_bitti & ~b_aralik) | ((v_durum_q == VTamam) & ~v_aralik);

    // Outputs. The fetch stall also rises combinationally when the address moves away
    // from the word held in the ready state, so the core never takes stale data.
    always_comb begin
        bus.l1b_bekle_o  = ~rst_ni | (b_durum_q != BHazir) | (bus.l1b_adres_i != b_adres_q);
        bus.bib_durdur_o = rst_ni & bus.bib_sec_i & (v_durum_q != VTamam);
    end

    assign bus.l1b_deger_o  = l1b_deger_q;
    assign bus.bib_veri_o   = bib_veri_q;
    assign hata_o           = hata_q;
    assign b_istek_sayisi_o = b_sayi_q;
    assign v_istek_sayisi_o = v_sayi_q;
endmodule

// File: tb/tb_bellek_yanitlayici.sv
// Self-checking bench for bellek_yanitlayici: reset values, directed data vectors, aborted
// and same-cycle corner cases, reset during a fetch, and random traffic against a
// word-array reference model.
module tb_bellek_yanitlayici;
    localparam int unsigned B_GEC = 1;
    localparam int unsigned V_GEC = 2;
    localparam int unsigned DER   = 4096;
    localparam logic [31:0] BASE  = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hata;
    logic [31:0] b_sayi, v_sayi;

    bellek_yanitlayici_if #(.VERI_GEN(32), .ADRES_GEN(32)) bus ();

    bellek_yanitlayici #(
        .VERI_GEN(32), .ADRES_GEN(32), .DERINLIK(DER), .ADRES_TABAN(BASE),
        .B_GECIKME(B_GEC), .V_GECIKME(V_GEC)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus), .hata_o(hata),
        .b_istek_sayisi_o(b_sayi), .v_istek_sayisi_o(v_sayi)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_mem [16];
    int          model_b, model_v;
    logic        model_hata;
    logic [31:0] son_adres;

    typedef struct {
        logic        yaz;
        logic [31:0] adr;
        logic [31:0] veri;
        logic [3:0]  maske;
        logic [31:0] beklenen;
        logic        hata_b;
    } vektor_t;
    vektor_t tablo [9];

    task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        checks++;
        if (gercek !== beklenen) begin
            errors++;
            $display("FAIL %s: got %h expected %h", ad, gercek, beklenen);
        end
    endtask

    function automatic logic aralikta(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(4 * DER));
    endfunction

    function automatic logic [31:0] model_oku(input logic [31:0] a);
        if (!aralikta(a)) return 32'h0;
        return model_mem[int'((a - BASE) >> 2)];
    endfunction

    task automatic model_yaz(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        if (aralikta(a)) begin
            for (int b = 0; b < 4; b++)
                if (m[b]) model_mem[int'((a - BASE) >> 2)][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // One data transaction; returns read data sampled in the completion cycle and the number
    // of stalled cycles seen.
    task automatic veri(input logic yaz, input logic [31:0] adr, input logic [31:0] d,
                        input logic [3:0] m, output logic [31:0] okunan, output int bekleme);
        @(posedge clk); #1;
        bus.bib_sec_i = 1'b1; bus.bib_yaz_gecerli_i = yaz; bus.bib_adr_i = adr;
        bus.bib_veri_i = d; bus.bib_veri_maske_i = m;
        bekleme = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.bib_durdur_o) break;
            bekleme++;
        end
        okunan = bus.bib_veri_o;
        @(posedge clk); #1;
        bus.bib_sec_i = 1'b0;
    endtask

    task automatic getir(input logic [31:0] adr, output logic [31:0] deger, output int bekleme);
        @(posedge clk); #1;
        bus.l1b_adres_i = adr;
        bekleme = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.l1b_bekle_o) break;
            bekleme++;
        end
        deger = bus.l1b_deger_o;
    endtask

    task automatic veri_kontrol(input logic yaz, input logic [31:0] adr, input logic [31:0] d,
                                input logic [3:0] m, input string ad);
        logic [31:0] okunan, beklenen;
        int bekleme;
        beklenen = model_oku(adr);
        veri(yaz, adr, d, m, okunan, bekleme);
        if (!aralikta(adr)) model_hata = 1'b1;
        if (yaz) model_yaz(adr, d, m);
        model_v++;
        kontrol({ad, " stall"}, bekleme, V_GEC);
        if (!yaz) kontrol({ad, " rdata"}, okunan, beklenen);
        kontrol({ad, " v_sayi"}, v_sayi, model_v);
        kontrol({ad, " hata"}, hata, model_hata);
    endtask

    task automatic getir_kontrol(input logic [31:0] adr, input string ad);
        logic [31:0] deger;
        int bekleme;
        getir(adr, deger, bekleme);
        if (!aralikta(adr)) model_hata = 1'b1;
        model_b++;
        son_adres = adr;
        kontrol({ad, " stall"}, bekleme, B_GEC + 1);
        kontrol({ad, " deger"}, deger, model_oku(adr));
        kontrol({ad, " b_sayi"}, b_sayi, model_b);
        kontrol({ad, " hata"}, hata, model_hata);
    endtask

    task automatic reset_kontrol(input string ad);
        kontrol({ad, " bekle"}, bus.l1b_bekle_o, 1);
        kontrol({ad, " durdur"}, bus.bib_durdur_o, 0);
        kontrol({ad, " b_sayi"}, b_sayi, 0);
        kontrol({ad, " v_sayi"}, v_sayi, 0);
        kontrol({ad, " hata"}, hata, 0);
        kontrol({ad, " l1b_deger"}, bus.l1b_deger_o, 0);
        kontrol({ad, " bib_veri"}, bus.bib_veri_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] okunan, deger, adr;
        int bekleme;

        tablo[0] = '{1'b1, 32'h4000_0010, 32'hAABB_CCDD, 4'b0101, 32'h0,         1'b0};
        tablo[1] = '{1'b0, 32'h4000_0010, 32'h0,         4'h0,    32'h00BB_00DD, 1'b0};
        tablo[2] = '{1'b1, 32'h4000_0004, 32'hDEAD_BEEF, 4'b0000, 32'h0,         1'b0};
        tablo[3] = '{1'b0, 32'h4000_0007, 32'h0,         4'h0,    32'hA5A5_0001, 1'b0};
        tablo[4] = '{1'b1, 32'h4000_0008, 32'h1234_5678, 4'b1010, 32'h0,         1'b0};
        tablo[5] = '{1'b0, 32'h4000_0008, 32'h0,         4'h0,    32'h12A5_5602, 1'b0};
        tablo[6] = '{1'b0, 32'h3FFF_FFFC, 32'h0,         4'h0,    32'h0,         1'b1};
        tablo[7] = '{1'b1, 32'h4000_4000, 32'hFFFF_FFFF, 4'hF,    32'h0,         1'b1};
        tablo[8] = '{1'b0, 32'h4000_0000, 32'h0,         4'h0,    32'h0000_0013, 1'b1};

        rst_n = 1'b0;
        bus.l1b_adres_i = BASE;
        bus.bib_sec_i = 1'b1;
        bus.bib_yaz_gecerli_i = 1'b0;
        bus.bib_adr_i = BASE;
        bus.bib_veri_i = '0;
        bus.bib_veri_maske_i = '0;
        #3;
        reset_kontrol("por");
        bus.bib_sec_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Preload a 16-word window through the data port.
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = (i == 0) ? 32'h13 : (i == 4) ? 32'h0 : (32'hA5A5_0000 | 32'(i));
            veri(1'b1, BASE + 32'(4 * i), model_mem[i], 4'hF, okunan, bekleme);
        end

        // Reset pulse: memory survives, first fetch takes reset cycle plus B_GEC.
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.bib_sec_i = 1'b1;
        #2;
        reset_kontrol("pulse");
        bus.bib_sec_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bekleme = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.l1b_bekle_o) break;
            bekleme++;
        end
        kontrol("first fetch stall", bekleme, B_GEC + 1);
        kontrol("first fetch deger", bus.l1b_deger_o, 32'h0000_0013);
        kontrol("first fetch b_sayi", b_sayi, 1);
        model_b = 1; model_v = 0; model_hata = 1'b0; son_adres = BASE;

        for (int i = 0; i < 9; i++) begin
            veri(tablo[i].yaz, tablo[i].adr, tablo[i].veri, tablo[i].maske, okunan, bekleme);
            if (tablo[i].yaz) model_yaz(tablo[i].adr, tablo[i].veri, tablo[i].maske);
            if (tablo[i].hata_b) model_hata = 1'b1;
            model_v++;
            kontrol($sformatf("vec%0d stall", i), bekleme, V_GEC);
            if (!tablo[i].yaz) kontrol($sformatf("vec%0d rdata", i), okunan, tablo[i].beklenen);
            kontrol($sformatf("vec%0d hata", i), hata, tablo[i].hata_b);
            kontrol($sformatf("vec%0d v_sayi", i), v_sayi, i + 1);
        end

        getir_kontrol(32'h4000_4000, "oor fetch");

        // Write request dropped during its wait: nothing committed, nothing counted.
        @(posedge clk); #1;
        bus.bib_sec_i = 1'b1; bus.bib_yaz_gecerli_i = 1'b1; bus.bib_adr_i = 32'h4000_0008;
        bus.bib_veri_i = 32'h0; bus.bib_veri_maske_i = 4'hF;
        @(negedge clk);
        kontrol("abort durdur req", bus.bib_durdur_o, 1);
        @(posedge clk); #1;
        bus.bib_sec_i = 1'b0;
        @(negedge clk);
        kontrol("abort durdur drop", bus.bib_durdur_o, 0);
        repeat (3) @(posedge clk);
        #1;
        kontrol("abort v_sayi", v_sayi, model_v);
        veri_kontrol(1'b0, 32'h4000_0008, 32'h0, 4'h0, "abort readback");

        // Fetch of word 4 completes on the same edge as a data write to word 4.
        veri_kontrol(1'b1, 32'h4000_0010, 32'h1111_1111, 4'hF, "pre write w4");
        @(posedge clk); #1;
        bus.bib_sec_i = 1'b1; bus.bib_yaz_gecerli_i = 1'b1; bus.bib_adr_i = 32'h4000_0010;
        bus.bib_veri_i = 32'h2222_2222; bus.bib_veri_maske_i = 4'hF;
        @(posedge clk); #1;
        bus.l1b_adres_i = 32'h4000_0010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.bib_sec_i = 1'b0;
        @(negedge clk);
        model_b++; model_v++; son_adres = 32'h4000_0010;
        model_mem[4] = 32'h2222_2222;
        kontrol("rbw deger", bus.l1b_deger_o, 32'h1111_1111);
        kontrol("rbw bekle", bus.l1b_bekle_o, 0);
        kontrol("rbw b_sayi", b_sayi, model_b);
        kontrol("rbw v_sayi", v_sayi, model_v);
        getir_kontrol(32'h4000_0014, "fetch w5");
        getir_kontrol(32'h4000_0010, "refetch w4");

        // Random traffic against the model.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 7) == 0) adr = 32'h3FFF_FFF0;
                else adr = BASE + 32'(4 * $urandom_range(0, 15));
                if (adr == son_adres) adr = (adr == 32'h3FFF_FFF0) ? BASE : adr + 32'd4;
                if (adr == BASE + 32'd64) adr = BASE;
                getir_kontrol(adr, $sformatf("rnd%0d fetch", n));
            end else begin
                if ($urandom_range(0, 7) == 0) adr = 32'h4000_4000 + 32'($urandom_range(0, 255));
                else adr = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
                veri_kontrol(1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom_range(0, 15)),
                             $sformatf("rnd%0d data", n));
            end
        end

        // Reset asserted while a fetch is waiting; the fetch restarts after release.
        adr = (son_adres == 32'h4000_000C) ? 32'h4000_0018 : 32'h4000_000C;
        @(posedge clk); #1;
        bus.l1b_adres_i = adr;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        kontrol("rst say bekle", bus.l1b_bekle_o, 1);
        kontrol("rst say b_sayi", b_sayi, 0);
        kontrol("rst say v_sayi", v_sayi, 0);
        kontrol("rst say hata", hata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bekleme = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.l1b_bekle_o) break;
            bekleme++;
        end
        model_b = 1; model_v = 0; model_hata = 1'b0; son_adres = adr;
        kontrol("rst restart stall", bekleme, B_GEC + 1);
        kontrol("rst restart deger", bus.l1b_deger_o, model_oku(adr));
        kontrol("rst restart b_sayi", b_sayi, 1);
        veri_kontrol(1'b0, 32'h4000_0014, 32'h0, 4'h0, "post rst read");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bellek_yanitlayici.md
Name: bellek_yanitlayici

Overview:
- Parametrised memory responder serving the core's two memory interfaces: the L1 instruction port (l1b_*) and the memory unit data port (bib_*).
- Each port has an independent, configurable wait-state count, which drives the core's stall inputs.
- Data writes use byte masks. Out-of-range accesses raise a sticky error flag.
- Sits next to cekirdek in core-level benches and FPGA bring-up as the replacement for fixed, zero-wait stimulus.

Parameters:
- VERI_GEN, 32, data width in bits (multiple of 8).
- ADRES_GEN, 32, address width.
- DERINLIK, 4096, depth in words.
- ADRES_TABAN, 32'h4000_0000, byte address of word 0.
- B_GECIKME, 1, instruction wait cycles (1..15).
- V_GECIKME, 2, data wait cycles (1..15).

Ports:
- clk_i, input, 1, clock.
- rst_ni, input, 1, reset, asynchronous, active-low.
- l1b_adres_i, input, ADRES_GEN, instruction fetch byte address.
- l1b_deger_o, output, VERI_GEN, fetched word.
- l1b_bekle_o, output, 1, instruction stall to core.
- bib_sec_i, input, 1, data request.
- bib_adr_i, input, ADRES_GEN, data byte address.
- bib_veri_i, input, VERI_GEN, write data.
- bib_veri_maske_i, input, VERI_GEN/8, byte write enables.
- bib_yaz_gecerli_i, input, 1, 1 = write, 0 = read.
- bib_veri_o, output, VERI_GEN, read data.
- bib_durdur_o, output, 1, data stall to core.
- hata_o, output, 1, sticky out-of-range flag.
- b_istek_sayisi_o, output, 32, completed instruction fetches.
- v_istek_sayisi_o, output, 32, completed data transactions.

Behaviour:
Reset
- rst_ni low clears, asynchronously: all FSMs to BOSTA, wait counters, hata_o, both request counters, l1b_deger_o and bib_veri_o.
- l1b_bekle_o = 1 while rst_ni is low and in the first cycle after release.
- bib_durdur_o = 0 during reset.
- Memory contents are not cleared.
- Reset mid-transaction aborts it; no write is committed.

Address decode
- Word index = (adr - ADRES_TABAN) >> 2. Low two address bits are ignored.
- In range only if ADRES_TABAN <= adr < ADRES_TABAN + 4*DERINLIK.

Instruction FSM (BOSTA, SAY, HAZIR)
- BOSTA to SAY when l1b_adres_i differs from the last served address, or on the first cycle after reset. Address is latched.
- SAY: l1b_bekle_o = 1 and the counter runs B_GECIKME cycles.
- SAY to HAZIR: l1b_deger_o is registered from memory, l1b_bekle_o = 0, b_istek_sayisi_o increments.
- HAZIR holds the data while the address is unchanged.
- An address change in HAZIR restarts SAY on the next cycle.
- An address change during SAY is ignored; the latched address is served.
- Out-of-range fetch returns 0 and sets hata_o.

Data FSM (BOSTA, SAY, TAMAM)
- bib_durdur_o = bib_sec_i & ~tamam, combinational, so the stall is visible in the same cycle as the request.
- BOSTA to SAY when bib_sec_i = 1. Address, data, mask and write flag are latched.
- SAY counts V_GECIKME cycles, then goes to TAMAM.
- TAMAM lasts one cycle:
  - Write: memory bytes whose mask bit is set are written at the closing edge.
  - Read: bib_veri_o is valid and held until the next read completes.
  - v_istek_sayisi_o increments.
- TAMAM to BOSTA. If bib_sec_i is still high, a new transaction starts; back-to-back transactions therefore cost V_GECIKME+1 cycles each.
- bib_sec_i dropping during SAY aborts: no write, no count.
- Out-of-range: write ignored, read returns 0, hata_o set.
- A write with mask 0 completes normally and changes nothing.

Simultaneous events
- Instruction read and data write of the same word in the same cycle: the instruction port returns the old value (read-before-write).
- Counters wrap at 2^32.

Test Plan:
- Reset release, then l1b_adres_i = 32'h4000_0000 with mem[0] = 32'h0000_0013, B_GECIKME = 1 -> l1b_bekle_o is 1 for 2 cycles (reset plus wait), then l1b_deger_o = 32'h0000_0013 and b_istek_sayisi_o = 1.
- Data write to 32'h4000_0010 with 32'hAABB_CCDD and mask 4'b0101 over old value 0, V_GECIKME = 2 -> bib_durdur_o high 2 cycles. A read of the same address returns 32'h00BB_00DD and v_istek_sayisi_o = 2.
- Read of 32'h3FFF_FFFC -> bib_veri_o = 0 and hata_o = 1, staying high through later valid accesses until reset.
- Same-cycle fetch and write of word 4 (old 32'h1111_1111, new 32'h2222_2222) -> l1b_deger_o = 32'h1111_1111; the next fetch of word 4 returns 32'h2222_2222.
- bib_sec_i dropped after 1 cycle of SAY during a write -> memory unchanged and v_istek_sayisi_o unchanged.
- rst_ni pulsed low during instruction SAY -> l1b_bekle_o = 1 with counters 0; after release, the fetch restarts and completes after B_GECIKME+1 cycles.
